// File: rtl/req_tagger.sv
// AR request tagger: assigns sequential tIDs, remembers each arid for the ROB,
// and caps outstanding requests at 2**TID_WIDTH so tIDs never alias.
module req_tagger #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8,
  parameter int TID_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [TID_WIDTH-1:0]  req_tid_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  ret_valid_i,
  input  logic [TID_WIDTH-1:0]  ret_tid_i,
  output logic [ID_WIDTH-1:0]   ret_rid_o,
  output logic [TID_WIDTH:0]    outstanding_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam int DEPTH = 1 << TID_WIDTH;
  localparam logic [TID_WIDTH:0] FULL_CNT = (TID_WIDTH+1)'(DEPTH);

  logic [TID_WIDTH-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [TID_WIDTH-1:0]  ret_ptr_q, ret_ptr_d;
  logic [TID_WIDTH:0]    count_q, count_d;
  logic [ID_WIDTH-1:0]   id_tbl_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_tbl_d [DEPTH];
  logic                  req_valid_q, req_valid_d;
  logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  err_q, err_d;

  logic full;
  logic ar_hs;
  logic ret_ok;

  // Full uses the registered count only; a retire never bypasses into arready.
  assign full      = (count_q == FULL_CNT);
  assign arready_o = !full && (!req_valid_q || req_ready_i);
  assign ar_hs     = arvalid_i && arready_o;
  assign ret_ok    = ret_valid_i && (count_q != '0);

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    ret_ptr_d   = ret_ptr_q;
    count_d     = count_q;
    id_tbl_d    = id_tbl_q;
    req_valid_d = req_valid_q;
    req_tid_d   = req_tid_q;
    req_addr_d  = req_addr_q;
    err_d       = err_q;

    if (ar_hs) begin
      req_valid_d           = 1'b1;
      req_tid_d             = alloc_ptr_q;
      req_addr_d            = araddr_i;
      id_tbl_d[alloc_ptr_q] = arid_i;
      alloc_ptr_d           = alloc_ptr_q + 1'b1;
    end else if (req_valid_q && req_ready_i) begin
      req_valid_d = 1'b0;
    end

    // Out-of-order retires are flagged but still consumed; empty retires are dropped.
    if (ret_valid_i) begin
      if (count_q == '0) begin
        err_d = 1'b1;
      end else begin
        ret_ptr_d = ret_ptr_q + 1'b1;
        if (ret_tid_i != ret_ptr_q) err_d = 1'b1;
      end
    end

    unique case ({ar_hs, ret_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      ret_ptr_q   <= '0;
      count_q     <= '0;
      req_valid_q <= 1'b0;
      req_tid_q   <= '0;
      req_addr_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) id_tbl_q[i] <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      ret_ptr_q   <= ret_ptr_d;
      count_q     <= count_d;
      req_valid_q <= req_valid_d;
      req_tid_q   <= req_tid_d;
      req_addr_q  <= req_addr_d;
      err_q       <= err_d;
      id_tbl_q    <= id_tbl_d;
    end
  end

  assign req_valid_o   = req_valid_q;
  assign req_tid_o     = req_tid_q;
  assign req_addr_o    = req_addr_q;
  assign ret_rid_o     = id_tbl_q[ret_tid_i];
  assign outstanding_o = count_q;
  assign empty_o       = (count_q == '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_req_tagger.sv
// Directed bench for req_tagger: tagging, backpressure, fill/refill,
// in-order and erroneous retires, simultaneous events and mid-burst reset.
module tb_req_tagger;

  localparam int AW = 64;
  localparam int IW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arvalid_i;
  logic          arready_o;
  logic [IW-1:0] arid_i;
  logic [AW-1:0] araddr_i;
  logic          req_valid_o;
  logic          req_ready_i;
  logic [TW-1:0] req_tid_o;
  logic [AW-1:0] req_addr_o;
  logic          ret_valid_i;
  logic [TW-1:0] ret_tid_i;
  logic [IW-1:0] ret_rid_o;
  logic [TW:0]   outstanding_o;
  logic          empty_o;
  logic          err_o;

  int n_cmp = 0;
  int n_bad = 0;

  req_tagger #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .arid_i(arid_i), .araddr_i(araddr_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_tid_o(req_tid_o),
    .req_addr_o(req_addr_o), .ret_valid_i(ret_valid_i), .ret_tid_i(ret_tid_i),
    .ret_rid_o(ret_rid_o), .outstanding_o(outstanding_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_arready"}, 64'(arready_o), 64'd1);
    chk({tag, "_req_valid"}, 64'(req_valid_o), 64'd0);
    chk({tag, "_req_tid"}, 64'(req_tid_o), 64'd0);
    chk({tag, "_req_addr"}, req_addr_o, 64'd0);
    chk({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    chk({tag, "_empty"}, 64'(empty_o), 64'd1);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_ret_rid"}, 64'(ret_rid_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arvalid_i = 0; arid_i = '0; araddr_i = '0;
    req_ready_i = 1'b1; ret_valid_i = 0; ret_tid_i = '0;
    step(); step();
    chk_reset_state("rst0");
    rst = 1'b0;

    // Three back-to-back ARs with ready=1
    arvalid_i = 1; arid_i = 8'd5; araddr_i = 64'h100; step();
    chk("b2b_v0", 64'(req_valid_o), 64'd1);
    chk("b2b_tid0", 64'(req_tid_o), 64'd0);
    chk("b2b_addr0", req_addr_o, 64'h100);
    arid_i = 8'd9; araddr_i = 64'h110; step();
    chk("b2b_tid1", 64'(req_tid_o), 64'd1);
    chk("b2b_addr1", req_addr_o, 64'h110);
    arid_i = 8'd2; araddr_i = 64'h120; step();
    chk("b2b_tid2", 64'(req_tid_o), 64'd2);
    arvalid_i = 0; step();
    chk("b2b_drain", 64'(req_valid_o), 64'd0);
    chk("b2b_outst", 64'(outstanding_o), 64'd3);

    // In-order retire of tIDs 0,1,2
    ret_valid_i = 1;
    ret_tid_i = 4'd0; #1; chk("ret_rid0", 64'(ret_rid_o), 64'd5); step();
    chk("ret_outst2", 64'(outstanding_o), 64'd2);
    ret_tid_i = 4'd1; #1; chk("ret_rid1", 64'(ret_rid_o), 64'd9); step();
    ret_tid_i = 4'd2; #1; chk("ret_rid2", 64'(ret_rid_o), 64'd2); step();
    ret_valid_i = 0;
    chk("ret_empty", 64'(empty_o), 64'd1);
    chk("ret_outst0", 64'(outstanding_o), 64'd0);
    chk("ret_err", 64'(err_o), 64'd0);

    // Backpressure: hold one request, next AR waits until ready returns
    req_ready_i = 0; arvalid_i = 1; arid_i = 8'd7; araddr_i = 64'h200; step();
    chk("bp_v", 64'(req_valid_o), 64'd1);
    chk("bp_tid", 64'(req_tid_o), 64'd3);
    arid_i = 8'd8; araddr_i = 64'h300; #1;
    chk("bp_arready", 64'(arready_o), 64'd0);
    step(); step();
    chk("bp_hold_tid", 64'(req_tid_o), 64'd3);
    chk("bp_hold_addr", req_addr_o, 64'h200);
    chk("bp_hold_v", 64'(req_valid_o), 64'd1);
    chk("bp_hold_outst", 64'(outstanding_o), 64'd1);
    req_ready_i = 1; #1;
    chk("bp_release_arready", 64'(arready_o), 64'd1);
    step();
    chk("bp_next_tid", 64'(req_tid_o), 64'd4);
    chk("bp_next_addr", req_addr_o, 64'h300);
    arvalid_i = 0; step();
    chk("bp_drain", 64'(req_valid_o), 64'd0);
    ret_valid_i = 1; ret_tid_i = 4'd3; #1;
    chk("bp_rid3", 64'(ret_rid_o), 64'd7);
    step();
    ret_tid_i = 4'd4; step();
    ret_valid_i = 0;
    chk("bp_empty", 64'(empty_o), 64'd1);

    // Retire on empty: error, count stays 0
    ret_valid_i = 1; ret_tid_i = 4'd5; step();
    ret_valid_i = 0;
    chk("empty_ret_err", 64'(err_o), 64'd1);
    chk("empty_ret_outst", 64'(outstanding_o), 64'd0);
    step();
    chk("empty_ret_sticky", 64'(err_o), 64'd1);

    rst = 1; #1; rst = 0;
    chk("rst1_err", 64'(err_o), 64'd0);

    // Out-of-order retire: tID 1 while ret_ptr=0
    arvalid_i = 1; arid_i = 8'h31; araddr_i = 64'h400; step();
    arid_i = 8'h32; araddr_i = 64'h410; step();
    arvalid_i = 0;
    chk("ooo_tid1", 64'(req_tid_o), 64'd1);
    ret_valid_i = 1; ret_tid_i = 4'd1; #1;
    chk("ooo_rid1", 64'(ret_rid_o), 64'h32);
    chk("ooo_err_before", 64'(err_o), 64'd0);
    step();
    ret_valid_i = 0;
    chk("ooo_err", 64'(err_o), 64'd1);
    chk("ooo_outst", 64'(outstanding_o), 64'd1);
    step(); step();
    chk("ooo_sticky", 64'(err_o), 64'd1);
    ret_valid_i = 1; ret_tid_i = 4'd1; step();
    ret_valid_i = 0;
    chk("ooo_outst0", 64'(outstanding_o), 64'd0);

    // Simultaneous AR and retire at count=7
    arvalid_i = 1;
    for (int i = 0; i < 7; i++) begin
      arid_i = 8'(8'h50 + i); araddr_i = 64'(64'h500 + i); step();
    end
    arvalid_i = 0; step();
    chk("sim_pre_outst", 64'(outstanding_o), 64'd7);
    arvalid_i = 1; arid_i = 8'h60; araddr_i = 64'h600;
    ret_valid_i = 1; ret_tid_i = 4'd2; step();
    ret_valid_i = 0;
    chk("sim_outst", 64'(outstanding_o), 64'd7);
    chk("sim_tid", 64'(req_tid_o), 64'd9);

    // Reset in the middle of a burst
    arid_i = 8'h61; araddr_i = 64'h610; step();
    chk("burst_tid", 64'(req_tid_o), 64'd10);
    rst = 1; #1;
    ret_tid_i = 4'd3;
    arvalid_i = 0;
    #1;
    chk_reset_state("rst2");
    step();
    rst = 0;

    // Fill to 16, 17th waits, retire tID 0 frees its slot
    arvalid_i = 1;
    for (int i = 0; i < 16; i++) begin
      arid_i = 8'(8'h40 + i); araddr_i = 64'(64'h1000 + i); step();
      chk($sformatf("fill_tid%0d", i), 64'(req_tid_o), 64'(i));
    end
    arid_i = 8'hAA; araddr_i = 64'hDEAD; #1;
    chk("full_arready", 64'(arready_o), 64'd0);
    chk("full_outst", 64'(outstanding_o), 64'd16);
    step();
    chk("full_hold_outst", 64'(outstanding_o), 64'd16);
    chk("full_drain", 64'(req_valid_o), 64'd0);
    ret_valid_i = 1; ret_tid_i = 4'd0; #1;
    chk("full_rid0_old", 64'(ret_rid_o), 64'h40);
    chk("full_arready_same", 64'(arready_o), 64'd0);
    step();
    ret_valid_i = 0;
    chk("refill_outst15", 64'(outstanding_o), 64'd15);
    chk("refill_arready", 64'(arready_o), 64'd1);
    step();
    arvalid_i = 0;
    chk("refill_tid", 64'(req_tid_o), 64'd0);
    chk("refill_addr", req_addr_o, 64'hDEAD);
    chk("refill_outst16", 64'(outstanding_o), 64'd16);
    chk("refill_rid0_new", 64'(ret_rid_o), 64'hAA);
    chk("refill_err", 64'(err_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
